out_port_demux: RTL and testbench

// - 1-to-4 write router; the opposite direction of the 4:1 select muxes in the MCU datapath.
// - One producer (MCU MMIO store path) issues (sel, data) words.
// - Each word is steered into one of four per-port FIFOs.
// - Each downstream peripheral drains its own port over valid/ready.
// - Sits between the MCU store/IOBUS logic and the output peripherals (LEDs, SSEG, UART TX, spare).

---
 rtl/out_port_demux_pkg.sv | 8 +
 rtl/out_port_demux_port_fifo.sv | 47 ++++
 rtl/out_port_demux.sv | 45 ++++
 tb/tb_out_port_demux.sv | 111 +++++++++++
 4 files changed

// File: rtl/out_port_demux_pkg.sv
// out_port_pkg: shared port count, select type and select decode for the output demux
package out_port_pkg;
    localparam int NUM_PORTS = 4;
    typedef logic [1:0] port_sel_t;
    function automatic logic [NUM_PORTS-1:0] sel_onehot(input port_sel_t s);
        return NUM_PORTS'(1) << s;
    endfunction
endpackage

// File: rtl/out_port_demux_port_fifo.sv
// port_fifo: per-port FIFO with a registered head word that holds its last value when drained
module port_fifo #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 2
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             push,
    input  logic [WIDTH-1:0] din,
    input  logic             pop,
    output logic [WIDTH-1:0] dout,
    output logic             valid,
    output logic             full
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wptr, r_rptr;
    logic [CW-1:0]    r_count;
    logic [WIDTH-1:0] r_dout;
    logic             w_push, w_pop;
    logic [AW-1:0]    w_rptr_nxt;
    logic [CW-1:0]    w_count_nxt;
    assign valid       = r_count != '0;
    assign full        = r_count == CW'(DEPTH);
    assign w_push      = push & ~full;
    assign w_pop       = pop & valid;
    assign w_rptr_nxt  = r_rptr + AW'(w_pop);
    assign w_count_nxt = r_count + CW'(w_push) - CW'(w_pop);
    assign dout        = r_dout;
    // Storage, pointers and the head register; the head takes the pushed word when it lands in the slot being read next
    always_ff @(posedge CLK) begin
        if (RST) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
            r_dout  <= '0;
        end else begin
            if (w_push) r_mem[r_wptr] <= din;
            r_wptr  <= r_wptr + AW'(w_push);
            r_rptr  <= w_rptr_nxt;
            r_count <= w_count_nxt;
            if (w_count_nxt != '0)
                r_dout <= (w_push && r_wptr == w_rptr_nxt) ? din : r_mem[w_rptr_nxt];
        end
    end
endmodule

// File: rtl/out_port_demux.sv
// out_port_demux: steers (sel, data) words from one producer into four per-port FIFOs
module out_port_demux
    import out_port_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int DEPTH = 2
) (
    input  logic                            CLK,
    input  logic                            RST,
    input  logic                            in_valid,
    input  logic [1:0]                      in_sel,
    input  logic [WIDTH-1:0]                in_data,
    output logic                            in_ready,
    output logic [NUM_PORTS-1:0]            out_valid,
    input  logic [NUM_PORTS-1:0]            out_ready,
    output logic [NUM_PORTS-1:0][WIDTH-1:0] out_data,
    output logic                            busy,
    output logic                            overflow
);
    logic [NUM_PORTS-1:0] w_full, w_push;
    logic                 w_transfer;
    logic                 r_overflow;
    assign in_ready   = ~w_full[in_sel];
    assign w_transfer = in_valid & in_ready;
    assign w_push     = {NUM_PORTS{w_transfer}} & sel_onehot(in_sel);
    assign busy       = |out_valid;
    assign overflow   = r_overflow;
    for (genvar p = 0; p < NUM_PORTS; p++) begin : g_port
        port_fifo #(.WIDTH(WIDTH), .DEPTH(DEPTH)) u_fifo (
            .CLK   (CLK),
            .RST   (RST),
            .push  (w_push[p]),
            .din   (in_data),
            .pop   (out_ready[p]),
            .dout  (out_data[p]),
            .valid (out_valid[p]),
            .full  (w_full[p])
        );
    end
    // Sticky flag for a word offered to a full port and therefore dropped
    always_ff @(posedge CLK) begin
        if (RST) r_overflow <= 1'b0;
        else if (in_valid & ~in_ready) r_overflow <= 1'b1;
    end
endmodule

// File: tb/tb_out_port_demux.sv
// tb_out_port_demux: directed and random checks of the demux against a queue-based port model
module tb_out_port_demux;
    import out_port_pkg::*;
    localparam int W = 32;
    localparam int D = 2;
    logic                  CLK = 1'b0;
    logic                  RST = 1'b1;
    logic                  in_valid = 1'b0;
    logic [1:0]            in_sel = '0;
    logic [W-1:0]          in_data = '0;
    logic                  in_ready;
    logic [3:0]            out_valid;
    logic [3:0]            out_ready = '0;
    logic [3:0][W-1:0]     out_data;
    logic                  busy, overflow;
    int n_cmp = 0;
    int n_err = 0;
    logic [W-1:0] q [4][$];
    logic [W-1:0] head [4];
    logic         m_ovf;

    out_port_demux #(.WIDTH(W), .DEPTH(D)) dut (
        .CLK(CLK), .RST(RST), .in_valid(in_valid), .in_sel(in_sel), .in_data(in_data),
        .in_ready(in_ready), .out_valid(out_valid), .out_ready(out_ready),
        .out_data(out_data), .busy(busy), .overflow(overflow)
    );

    initial forever #5 CLK = ~CLK;

    task automatic check(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int p = 0; p < 4; p++) begin
            q[p].delete();
            head[p] = '0;
        end
        m_ovf = 1'b0;
    endtask

    task automatic check_outputs();
        for (int p = 0; p < 4; p++) begin
            check($sformatf("out_valid[%0d]", p), W'(out_valid[p]), W'(q[p].size() > 0));
            check($sformatf("out_data[%0d]", p), out_data[p], head[p]);
        end
        check("busy", W'(busy), W'(q[0].size() + q[1].size() + q[2].size() + q[3].size() > 0));
        check("overflow", W'(overflow), W'(m_ovf));
    endtask

    task automatic step(input logic rst, input logic v, input logic [1:0] s,
                        input logic [W-1:0] d, input logic [3:0] ordy, input logic xsel = 1'b0);
        bit push_ok;
        RST       = rst;
        in_valid  = v;
        in_sel    = xsel ? 2'bxx : s;
        in_data   = xsel ? 'x : d;
        out_ready = ordy;
        #1;
        if (!xsel) check("in_ready", W'(in_ready), W'(q[s].size() < D));
        push_ok = v && q[s].size() < D;
        if (rst) model_reset();
        else begin
            if (v && !push_ok) m_ovf = 1'b1;
            for (int p = 0; p < 4; p++)
                if (ordy[p] && q[p].size() > 0) void'(q[p].pop_front());
            if (push_ok) q[s].push_back(d);
            for (int p = 0; p < 4; p++)
                if (q[p].size() > 0) head[p] = q[p][0];
        end
        @(posedge CLK);
        #1;
        check_outputs();
    endtask

    initial begin
        bit r, v, x;
        RST = 1'b1;
        repeat (2) @(posedge CLK);
        #1;
        model_reset();
        check_outputs();
        for (int s = 0; s < 4; s++) begin
            in_sel = 2'(s);
            #1;
            check($sformatf("reset in_ready sel%0d", s), W'(in_ready), W'(1));
        end
        step(0, 1, 2, 32'hDEAD_BEEF, 4'b0000);
        step(0, 1, 1, 32'hA1A1_0001, 4'b0000);
        step(0, 1, 1, 32'hA2A2_0002, 4'b0000);
        step(0, 1, 1, 32'hA3A3_0003, 4'b0000);
        step(0, 1, 0, 32'h0000_0005, 4'b0000);
        repeat (3) step(0, 0, 1, '0, 4'b0010);
        step(0, 1, 3, 32'hB000_0000, 4'b0000);
        for (int i = 1; i <= 8; i++) step(0, 1, 3, 32'hB000_0000 + W'(i), 4'b1000);
        step(1, 1, 2, 32'h1234_5678, 4'b0000);
        step(0, 0, 0, '0, 4'b0000);
        for (int i = 0; i < 500; i++) begin
            r = $urandom_range(0, 59) == 0;
            v = $urandom_range(0, 2) != 0;
            x = !v && $urandom_range(0, 3) == 0;
            step(r, v, 2'($urandom_range(0, 3)), $urandom, 4'($urandom), x);
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
